// File: rtl/soc_system_key_pio_in_pkg.sv
// soc_system_key_pio_in_pkg: shared PIO register map, edge encodings and counter sizing
package soc_system_key_pio_in_pkg;
  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_DIR  = 2'd1;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/soc_system_pio_debounce_bit.sv
// soc_system_pio_debounce_bit: 2-flop synchroniser plus stable-time filter for one input bit
module soc_system_pio_debounce_bit
  import soc_system_key_pio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk)
    if (!reset_n) begin
      s1_q <= IDLE_LEVEL;
      s2_q <= IDLE_LEVEL;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
    end
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign stable_o = s2_q;
  end else begin : g_filter
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic stable_q, stable_d, differ;
    // any return to the stable level restarts the count, so short glitches never commit
    always_comb begin
      differ = s2_q != stable_q;
      cnt_d = (!differ || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      stable_d = (differ && cnt_q == LAST) ? s2_q : stable_q;
    end
    always_ff @(posedge clk)
      if (!reset_n) begin
        cnt_q <= '0;
        stable_q <= IDLE_LEVEL;
      end else begin
        cnt_q <= cnt_d;
        stable_q <= stable_d;
      end
    assign stable_o = stable_q;
  end
endmodule

// File: rtl/soc_system_key_pio_in.sv
// soc_system_key_pio_in: debounced Avalon-MM input PIO with edge capture and maskable irq
module soc_system_key_pio_in
  import soc_system_key_pio_in_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE = 1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] stable, prev_q, edge_det, mask_q, mask_d, cap_q, cap_d;
  logic [31:0] rd_q, rd_d;
  logic wr, unused_wd;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL(IDLE_LEVEL)
    ) u_db (
      .clk(clk),
      .reset_n(reset_n),
      .in_i(in_port[i]),
      .stable_o(stable[i])
    );
  end
  assign wr = chipselect && !write_n;
  assign unused_wd = ^writedata;
  // a new edge overrides a same-cycle write-1-to-clear on that bit
  always_comb begin
    edge_det = (EDGE_TYPE == EDGE_RISE) ? stable & ~prev_q :
               (EDGE_TYPE == EDGE_FALL) ? ~stable & prev_q : stable ^ prev_q;
    mask_d = (wr && address == PIO_MASK) ? writedata[WIDTH-1:0] : mask_q;
    cap_d = ((wr && address == PIO_EDGE) ? cap_q & ~writedata[WIDTH-1:0] : cap_q) | edge_det;
    rd_d = (address == PIO_DATA) ? 32'(stable) :
           (address == PIO_MASK) ? 32'(mask_q) :
           (address == PIO_EDGE) ? 32'(cap_q) : '0;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      prev_q <= {WIDTH{IDLE_LEVEL}};
      mask_q <= '0;
      cap_q <= '0;
      rd_q <= '0;
    end else begin
      prev_q <= stable;
      mask_q <= mask_d;
      cap_q <= cap_d;
      rd_q <= rd_d;
    end
  assign readdata = rd_q;
  assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_soc_system_key_pio_in.sv
// tb_soc_system_key_pio_in: directed self-checking bench, WIDTH=4, DEBOUNCE_CYCLES=8, falling edges
module tb_soc_system_key_pio_in;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0] in_port = 4'hF;
  logic [31:0] readdata;
  logic irq;
  int checks = 0;
  int errors = 0;

  soc_system_key_pio_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(8),
    .EDGE_TYPE(1),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    step();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    repeat (3) step();
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    address = 2'd0;
    step();
    check("idle_data", readdata, 32'hF);
    address = 2'd3;
    for (int k = 0; k < 12; k++) begin
      step();
      check("idle_irq", {31'b0, irq}, 32'h0);
    end
    check("idle_cap", readdata, 32'h0);
    in_port = 4'hD;
    repeat (5) step();
    in_port = 4'hF;
    address = 2'd0;
    repeat (14) step();
    check("glitch_data", readdata, 32'hF);
    address = 2'd3;
    step();
    check("glitch_cap", readdata, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);
    address = 2'd0;
    in_port = 4'hB;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 10) check("fall_data_early", readdata, 32'hF);
      if (k == 11) check("fall_data", readdata, 32'hB);
    end
    address = 2'd3;
    step();
    check("fall_cap", readdata, 32'h4);
    check("fall_irq_masked", {31'b0, irq}, 32'h0);
    bus_wr(2'd2, 32'h4);
    check("mask_irq", {31'b0, irq}, 32'h1);
    step();
    check("mask_rd", readdata, 32'h4);
    bus_wr(2'd3, 32'h4);
    check("clr_irq", {31'b0, irq}, 32'h0);
    step();
    check("clr_cap", readdata, 32'h0);
    in_port = 4'hF;
    repeat (14) step();
    check("rise_not_captured", readdata, 32'h0);
    check("rise_irq", {31'b0, irq}, 32'h0);
    in_port = 4'hB;
    repeat (10) step();
    bus_wr(2'd3, 32'h4);
    step();
    check("set_wins_cap", readdata, 32'h4);
    check("set_wins_irq", {31'b0, irq}, 32'h1);
    bus_wr(2'd0, 32'hFF);
    bus_wr(2'd1, 32'hFF);
    address = 2'd0;
    step();
    check("ro_data", readdata, 32'hB);
    address = 2'd1;
    step();
    check("dir_zero", readdata, 32'h0);
    bus_wr(2'd2, 32'hFFFF_FFFF);
    step();
    check("mask_width", readdata, 32'hF);
    address = 2'd3;
    step();
    check("cap_kept", readdata, 32'h4);
    in_port = 4'h3;
    repeat (5) step();
    reset_n = 1'b0;
    step();
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    check("mid_rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    address = 2'd0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) check("post_rst_data_idle", readdata, 32'hF);
      if (k == 10) check("post_rst_data_early", readdata, 32'hF);
      if (k == 11) check("post_rst_data", readdata, 32'h3);
    end
    address = 2'd2;
    step();
    check("post_rst_mask", readdata, 32'h0);
    address = 2'd3;
    step();
    check("post_rst_cap", readdata, 32'hC);
    check("post_rst_irq", {31'b0, irq}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
